// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller.
// Takes two WIDTH-bit operands and a carry-in, then feeds one bit pair per clock
// (LSB first) plus the registered running carry to an external 1-bit full adder.
// The sum bits and the final carry are collected, and done is pulsed for one cycle.
module serial_adder_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_s,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C_out
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             c_out_q, c_out_d;

  // The incoming sum bit enters at the MSB. The result is taken as a slice of
  // {fa_s, sum_sh_q}, so WIDTH=1 still works (no [0:1] slice is formed).
  logic [WIDTH:0] sum_cat;
  assign sum_cat = {fa_s, sum_sh_q};

  // Next-state and output decode for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path leaves one
    // unassigned and no latch is inferred.
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    count_d  = count_q;
    s_d      = s_q;
    c_out_d  = c_out_q;
    fa_a     = 1'b0;
    fa_b     = 1'b0;
    fa_cin   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d   = A;
          b_sh_d   = B;
          carry_d  = C_in;
          count_d  = '0;
          sum_sh_d = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        busy     = 1'b1;
        fa_a     = a_sh_q[0];
        fa_b     = b_sh_q[0];
        fa_cin   = carry_q;
        sum_sh_d = sum_cat[WIDTH:1];
        carry_d  = fa_cout;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        count_d  = count_q + CW'(1);
        if (count_q == LAST) begin
          // The last bit goes straight into the result register, so S and
          // C_out keep the previous result until this edge.
          s_d     = sum_cat[WIDTH:1];
          c_out_d = fa_cout;
          state_d = DONE;
        end
      end

      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, with a synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments. Every register
    // updates from values sampled before the edge, so the order of the
    // statements does not matter.
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      count_q  <= '0;
      s_q      <= '0;
      c_out_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      count_q  <= count_d;
      s_q      <= s_d;
      c_out_q  <= c_out_d;
    end
  end

  assign S     = s_q;
  assign C_out = c_out_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl. It has three instances: WIDTH=4
// (sequences, timing, reset), WIDTH=8 (random sums) and WIDTH=1 (exhaustive).
// Each instance drives a behavioural full-adder cell.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- WIDTH=4 instance ----------------
  logic       w4_start, w4_c_in, w4_fa_a, w4_fa_b, w4_fa_cin, w4_fa_s, w4_fa_cout;
  logic       w4_busy, w4_done, w4_c_out;
  logic [3:0] w4_a, w4_b, w4_s;

  assign w4_fa_s    = w4_fa_a ^ w4_fa_b ^ w4_fa_cin;
  assign w4_fa_cout = (w4_fa_a & w4_fa_b) | (w4_fa_a & w4_fa_cin) | (w4_fa_b & w4_fa_cin);

  serial_adder_ctrl #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .start(w4_start), .A(w4_a), .B(w4_b), .C_in(w4_c_in),
    .fa_a(w4_fa_a), .fa_b(w4_fa_b), .fa_cin(w4_fa_cin), .fa_s(w4_fa_s), .fa_cout(w4_fa_cout),
    .busy(w4_busy), .done(w4_done), .S(w4_s), .C_out(w4_c_out)
  );

  // ---------------- WIDTH=8 instance ----------------
  logic       w8_start, w8_c_in, w8_fa_a, w8_fa_b, w8_fa_cin, w8_fa_s, w8_fa_cout;
  logic       w8_busy, w8_done, w8_c_out;
  logic [7:0] w8_a, w8_b, w8_s;

  assign w8_fa_s    = w8_fa_a ^ w8_fa_b ^ w8_fa_cin;
  assign w8_fa_cout = (w8_fa_a & w8_fa_b) | (w8_fa_a & w8_fa_cin) | (w8_fa_b & w8_fa_cin);

  serial_adder_ctrl #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .start(w8_start), .A(w8_a), .B(w8_b), .C_in(w8_c_in),
    .fa_a(w8_fa_a), .fa_b(w8_fa_b), .fa_cin(w8_fa_cin), .fa_s(w8_fa_s), .fa_cout(w8_fa_cout),
    .busy(w8_busy), .done(w8_done), .S(w8_s), .C_out(w8_c_out)
  );

  // ---------------- WIDTH=1 instance ----------------
  logic       w1_start, w1_c_in, w1_fa_a, w1_fa_b, w1_fa_cin, w1_fa_s, w1_fa_cout;
  logic       w1_busy, w1_done, w1_c_out;
  logic [0:0] w1_a, w1_b, w1_s;

  assign w1_fa_s    = w1_fa_a ^ w1_fa_b ^ w1_fa_cin;
  assign w1_fa_cout = (w1_fa_a & w1_fa_b) | (w1_fa_a & w1_fa_cin) | (w1_fa_b & w1_fa_cin);

  serial_adder_ctrl #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .start(w1_start), .A(w1_a), .B(w1_b), .C_in(w1_c_in),
    .fa_a(w1_fa_a), .fa_b(w1_fa_b), .fa_cin(w1_fa_cin), .fa_s(w1_fa_s), .fa_cout(w1_fa_cout),
    .busy(w1_busy), .done(w1_done), .S(w1_s), .C_out(w1_c_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Result the WIDTH=4 instance should currently be showing on S/C_out.
  logic [3:0] w4_prev_s;
  logic       w4_prev_c;

  // One WIDTH=4 add with a single-cycle start. Bit i of exp_fa_a/exp_fa_cin is
  // the value expected in RUN cycle i.
  task automatic run_add4(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic cin, input logic [3:0] exp_s, input logic exp_c,
                          input logic [3:0] exp_fa_a, input logic [3:0] exp_fa_cin);
    logic [3:0] seen_a, seen_cin;
    int         busy_cycles;
    busy_cycles = 0;
    @(negedge clk);
    w4_a = a; w4_b = b; w4_c_in = cin; w4_start = 1'b1;
    @(negedge clk);
    // Scramble the operands after acceptance; they must not matter.
    w4_start = 1'b0; w4_a = ~a; w4_b = ~b; w4_c_in = ~cin;
    for (int i = 0; i < 4; i++) begin
      seen_a[i]   = w4_fa_a;
      seen_cin[i] = w4_fa_cin;
      if (w4_busy) busy_cycles++;
      check({tag, "_run_done"}, w4_done, 1'b0);
      check({tag, "_s_held"}, {w4_c_out, w4_s}, {w4_prev_c, w4_prev_s});
      @(negedge clk);
    end
    if (w4_busy) busy_cycles++;
    check({tag, "_done"}, w4_done, 1'b1);
    check({tag, "_sum"}, {w4_c_out, w4_s}, {exp_c, exp_s});
    check({tag, "_fa_a_seq"}, seen_a, exp_fa_a);
    check({tag, "_fa_cin_seq"}, seen_cin, exp_fa_cin);
    @(negedge clk);
    if (w4_busy) busy_cycles++;
    check({tag, "_done_pulse"}, w4_done, 1'b0);
    check({tag, "_busy_cycles"}, busy_cycles, 5);
    w4_prev_s = exp_s;
    w4_prev_c = exp_c;
  endtask

  // One WIDTH=8 add. The expected sum comes from ordinary integer addition,
  // and done must appear WIDTH+1 cycles after acceptance.
  task automatic run_add8(input logic [7:0] a, input logic [7:0] b, input logic cin);
    logic [8:0] exp;
    int         lat;
    bit         seen;
    exp = 9'(a) + 9'(b) + 9'(cin);
    @(negedge clk);
    w8_a = a; w8_b = b; w8_c_in = cin; w8_start = 1'b1;
    @(negedge clk);
    w8_start = 1'b0;
    lat = 1; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (w8_done) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    check("w8_done_seen", seen, 1'b1);
    if (seen) begin
      check("w8_sum", {w8_c_out, w8_s}, exp);
      check("w8_latency", lat, 9);
    end
  endtask

  // One WIDTH=1 add: a single RUN cycle, so done appears 2 cycles after acceptance.
  task automatic run_add1(input logic a, input logic b, input logic cin);
    logic [1:0] exp;
    int         lat;
    bit         seen;
    exp = 2'(a) + 2'(b) + 2'(cin);
    @(negedge clk);
    w1_a = a; w1_b = b; w1_c_in = cin; w1_start = 1'b1;
    @(negedge clk);
    w1_start = 1'b0;
    lat = 1; seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (w1_done) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    check("w1_done_seen", seen, 1'b1);
    if (seen) begin
      check("w1_sum", {w1_c_out, w1_s}, exp);
      check("w1_latency", lat, 2);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    w4_start = 1'b0; w4_a = '0; w4_b = '0; w4_c_in = 1'b0;
    w8_start = 1'b0; w8_a = '0; w8_b = '0; w8_c_in = 1'b0;
    w1_start = 1'b0; w1_a = '0; w1_b = '0; w1_c_in = 1'b0;
    w4_prev_s = 4'd0; w4_prev_c = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state.
    check("rst_busy", w4_busy, 1'b0);
    check("rst_done", w4_done, 1'b0);
    check("rst_result", {w4_c_out, w4_s}, 5'd0);
    check("rst_fa", {w4_fa_a, w4_fa_b, w4_fa_cin}, 3'b000);

    // Directed WIDTH=4 adds.
    run_add4("add_5_3", 4'd5, 4'd3, 1'b0, 4'd8, 1'b0, 4'b0101, 4'b1110);
    run_add4("add_15_1", 4'd15, 4'd1, 1'b0, 4'd0, 1'b1, 4'b1111, 4'b1110);
    run_add4("add_15_15_1", 4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 4'b1111, 4'b1111);

    // start held high: an add every 6 cycles. A briefly changes to 7 mid-RUN.
    // After the acceptance edge, negedge n sees done at n = 5, 11, 17.
    @(negedge clk);
    w4_a = 4'd2; w4_b = 4'd2; w4_c_in = 1'b0; w4_start = 1'b1;
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      check("held_done", w4_done, (n == 5 || n == 11 || n == 17) ? 1'b1 : 1'b0);
      if (n == 5 || n == 11 || n == 17)
        check("held_sum", {w4_c_out, w4_s}, 5'd4);
      if (n == 8)  w4_a = 4'd7;
      if (n == 11) w4_a = 4'd2;
      if (n == 17) w4_start = 1'b0;
    end
    w4_prev_s = 4'd4; w4_prev_c = 1'b0;

    // Reset during the 2nd RUN cycle abandons the add.
    run_add4("pre_rst", 4'd5, 4'd3, 1'b0, 4'd8, 1'b0, 4'b0101, 4'b1110);
    @(negedge clk);
    w4_a = 4'd9; w4_b = 4'd9; w4_start = 1'b1;
    @(negedge clk);
    w4_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_busy", w4_busy, 1'b0);
    check("midrst_result", {w4_c_out, w4_s}, 5'd0);
    check("midrst_fa", {w4_fa_a, w4_fa_b, w4_fa_cin}, 3'b000);
    for (int i = 0; i < 6; i++) begin
      check("midrst_no_done", w4_done, 1'b0);
      @(negedge clk);
    end

    // WIDTH=8: corner cases, then random vectors.
    run_add8(8'hFF, 8'hFF, 1'b1);
    run_add8(8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 200; i++)
      run_add8(8'($urandom), 8'($urandom), 1'($urandom));

    // WIDTH=1: exhaustive.
    for (int v = 0; v < 8; v++) begin
      logic [2:0] vec;
      vec = 3'(v);
      run_add1(vec[2], vec[1], vec[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
